// File: rtl/cluster_pkg.sv
// Shared constants and types for the cluster unpacker: frame geometry,
// the "no cluster" address code, err_flags bit positions and FSM states.
package cluster_pkg;

    localparam int unsigned MXPADS       = 768;
    localparam int unsigned MXCLUSTERS   = 8;
    localparam logic [10:0] CLUSTER_NONE = 11'h7FF;

    localparam int unsigned ERR_BAD_ADR  = 0;
    localparam int unsigned ERR_TRUNC    = 1;
    localparam int unsigned ERR_OVERLAP  = 2;
    localparam int unsigned ERR_OVERFLOW = 3;

    typedef enum logic {
        SYNC_WAIT,
        ACCUM
    } state_t;

endpackage

// File: rtl/cluster_mask_expand.sv
// Combinational expansion of a cluster word (first strip, size-1) into a
// strip mask, clipped at the last strip, with a truncation indication.
module cluster_mask_expand
    import cluster_pkg::*;
#(
    parameter int unsigned MXPADS = cluster_pkg::MXPADS
) (
    input  logic [10:0]       adr_i,
    input  logic [2:0]        cnt_i,
    output logic [MXPADS-1:0] mask_o,
    output logic              truncated_o
);

    logic [7:0]  run;
    logic [11:0] last;

    always_comb begin
        // cnt+1 contiguous ones, shifted into place; bits beyond the frame fall off
        run         = 8'hFF >> (3'd7 - cnt_i);
        mask_o      = {{(MXPADS-8){1'b0}}, run} << adr_i;
        last        = {1'b0, adr_i} + {9'd0, cnt_i};
        truncated_o = last > 12'(MXPADS - 1);
    end

endmodule

// File: rtl/cluster_unpacker.sv
// Rebuilds a per-frame strip bitmap from a stream of cluster words (one per
// pass), reporting accepted-cluster count, error flags and pass-sequence errors.
module cluster_unpacker
    import cluster_pkg::*;
#(
    parameter int unsigned MXPADS     = cluster_pkg::MXPADS,
    parameter int unsigned MXCLUSTERS = cluster_pkg::MXCLUSTERS
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              frame_sync,
    input  logic [2:0]        pass,
    input  logic              cluster_found,
    input  logic [10:0]       adr,
    input  logic [2:0]        cnt,
    output logic [MXPADS-1:0] vpfs_out,
    output logic [3:0]        n_clusters,
    output logic              frame_valid,
    output logic [3:0]        err_flags,
    output logic              pass_err
);

    localparam logic [3:0]  MAXC = 4'(MXCLUSTERS);
    localparam logic [10:0] PADS = 11'(MXPADS);

    state_t            state_q;
    logic [MXPADS-1:0] work_q, work_d, base_map, mask;
    logic [3:0]        nacc_q, nacc_d, base_cnt;
    logic [3:0]        flags_q, flags_d;
    logic [2:0]        exp_q, exp_cur;
    logic [3:0]        since_q;
    logic              trunc, active, valid_word, in_range, room, accept, short_frame;

    cluster_mask_expand #(.MXPADS(MXPADS)) u_expand (
        .adr_i       (adr),
        .cnt_i       (cnt),
        .mask_o      (mask),
        .truncated_o (trunc)
    );

    // On frame_sync the pass-0 word lands on a cleared working state
    always_comb begin
        active      = (state_q == ACCUM) || frame_sync;
        base_map    = frame_sync ? '0 : work_q;
        base_cnt    = frame_sync ? '0 : nacc_q;
        flags_d     = frame_sync ? '0 : flags_q;
        valid_word  = cluster_found && (adr != CLUSTER_NONE);
        in_range    = adr < PADS;
        room        = base_cnt < MAXC;
        accept      = active && valid_word && in_range && room;
        work_d      = base_map;
        nacc_d      = base_cnt;
        if (accept) begin
            work_d = base_map | mask;
            nacc_d = base_cnt + 4'd1;
            if (trunc)
                flags_d[ERR_TRUNC] = 1'b1;
            if (|(base_map & mask))
                flags_d[ERR_OVERLAP] = 1'b1;
        end
        if (active && valid_word && !in_range)
            flags_d[ERR_BAD_ADR] = 1'b1;
        if (active && valid_word && in_range && !room)
            flags_d[ERR_OVERFLOW] = 1'b1;
        exp_cur     = frame_sync ? 3'd0 : exp_q;
        short_frame = frame_sync && (state_q == ACCUM) && (since_q < 4'd8);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= SYNC_WAIT;
            work_q      <= '0;
            nacc_q      <= '0;
            flags_q     <= '0;
            exp_q       <= '0;
            since_q     <= '0;
            vpfs_out    <= '0;
            n_clusters  <= '0;
            err_flags   <= '0;
            frame_valid <= 1'b0;
            pass_err    <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            pass_err    <= active && ((pass != exp_cur) || short_frame);
            exp_q       <= exp_cur + 3'd1;
            work_q      <= work_d;
            nacc_q      <= nacc_d;
            flags_q     <= flags_d;
            if (frame_sync)
                since_q <= 4'd1;
            else if (since_q < 4'd8)
                since_q <= since_q + 4'd1;
            case (state_q)
                SYNC_WAIT: if (frame_sync) state_q <= ACCUM;
                ACCUM: if (frame_sync) begin
                    vpfs_out    <= work_q;
                    n_clusters  <= nacc_q;
                    err_flags   <= flags_q;
                    frame_valid <= 1'b1;
                end
                default: state_q <= SYNC_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_cluster_unpacker.sv
// Self-checking bench for cluster_unpacker: single-word frame table plus
// hand sequences for overlap, overflow, short frames, pass errors and reset.
module tb_cluster_unpacker;

    localparam int NP = 768;
    localparam logic [10:0] NONE = 11'h7FF;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          frame_sync = 1'b0;
    logic [2:0]    pass = '0;
    logic          cluster_found = 1'b0;
    logic [10:0]   adr = NONE;
    logic [2:0]    cnt = '0;
    logic [NP-1:0] vpfs_out;
    logic [3:0]    n_clusters, err_flags;
    logic          frame_valid, pass_err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [NP-1:0] map;
        logic [3:0]    n;
        logic [3:0]    flags;
    } frame_t;

    typedef struct {
        logic        found;
        logic [10:0] adr;
        logic [2:0]  cnt;
        int          lo;
        int          hi;
        logic [3:0]  n;
        logic [3:0]  flags;
    } vec_t;

    frame_t sb[$];
    frame_t held;

    cluster_unpacker #(.MXPADS(NP), .MXCLUSTERS(8)) dut (
        .clock         (clock),
        .reset         (reset),
        .frame_sync    (frame_sync),
        .pass          (pass),
        .cluster_found (cluster_found),
        .adr           (adr),
        .cnt           (cnt),
        .vpfs_out      (vpfs_out),
        .n_clusters    (n_clusters),
        .frame_valid   (frame_valid),
        .err_flags     (err_flags),
        .pass_err      (pass_err)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [NP-1:0] range_map(input int lo, input int hi);
        logic [NP-1:0] m = '0;
        for (int i = 0; i < NP; i++)
            if (i >= lo && i <= hi) m[i] = 1'b1;
        return m;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_frame(input string tag, input frame_t e);
        int first = -1;
        int gotn = 0;
        int wantn = 0;
        checks++;
        if (vpfs_out !== e.map) begin
            for (int i = 0; i < NP; i++) begin
                if (vpfs_out[i] === 1'b1) gotn++;
                if (e.map[i]) wantn++;
                if (first < 0 && vpfs_out[i] !== e.map[i]) first = i;
            end
            errors++;
            $display("FAIL %s vpfs_out: got %0d strips set (first diff at %0d), expected %0d strips set",
                     tag, gotn, first, wantn);
        end
        chk({tag, " n_clusters"}, 32'(n_clusters), 32'(e.n));
        chk({tag, " err_flags"}, 32'(err_flags), 32'(e.flags));
    endtask

    // Scoreboard consumer plus hold check between frame_valid pulses
    always @(negedge clock) begin
        frame_t e;
        if (reset) begin
            held.map   = '0;
            held.n     = '0;
            held.flags = '0;
        end else if (frame_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected frame_valid: got 1 expected 0");
            end else begin
                e = sb.pop_front();
                check_frame("frame", e);
                held = e;
            end
        end else begin
            check_frame("hold", held);
        end
    end

    // Drive one cycle, then check pass_err produced by that word
    task automatic drive(input logic fs, input logic [2:0] p, input logic f,
                         input logic [10:0] a, input logic [2:0] c, input logic pe);
        frame_sync = fs; pass = p; cluster_found = f; adr = a; cnt = c;
        @(posedge clock);
        #1;
        chk("pass_err", 32'(pass_err), 32'(pe));
    endtask

    function automatic frame_t mk(input vec_t v);
        frame_t f;
        f.map   = range_map(v.lo, v.hi);
        f.n     = v.n;
        f.flags = v.flags;
        return f;
    endfunction

    initial begin
        vec_t   tbl [10];
        frame_t f;

        tbl[0] = '{1'b1, 11'd10,  3'd2, 10,  12,  4'd1, 4'b0000};
        tbl[1] = '{1'b1, 11'd765, 3'd5, 765, 767, 4'd1, 4'b0010};
        tbl[2] = '{1'b1, 11'd800, 3'd0, 1,   0,   4'd0, 4'b0001};
        tbl[3] = '{1'b0, 11'd50,  3'd3, 1,   0,   4'd0, 4'b0000};
        tbl[4] = '{1'b1, NONE,    3'd1, 1,   0,   4'd0, 4'b0000};
        tbl[5] = '{1'b1, 11'd0,   3'd7, 0,   7,   4'd1, 4'b0000};
        tbl[6] = '{1'b1, 11'd767, 3'd0, 767, 767, 4'd1, 4'b0000};
        tbl[7] = '{1'b1, 11'd760, 3'd7, 760, 767, 4'd1, 4'b0000};
        tbl[8] = '{1'b1, 11'd761, 3'd7, 761, 767, 4'd1, 4'b0010};
        tbl[9] = '{1'b1, 11'd768, 3'd0, 1,   0,   4'd0, 4'b0001};

        repeat (2) drive(1'b0, 3'd0, 1'b0, NONE, 3'd0, 1'b0);
        chk("reset vpfs_out zero", 32'(vpfs_out !== '0), 32'd0);
        chk("reset frame_valid", 32'(frame_valid), 32'd0);
        reset = 1'b0;

        // SYNC_WAIT ignores words
        drive(1'b0, 3'd3, 1'b1, 11'd40, 3'd1, 1'b0);

        for (int i = 0; i < 10; i++) begin
            if (i > 0) sb.push_back(mk(tbl[i-1]));
            drive(1'b1, 3'd0, tbl[i].found, tbl[i].adr, tbl[i].cnt, 1'b0);
            for (int p = 1; p < 8; p++) drive(1'b0, 3'(p), 1'b0, NONE, 3'd0, 1'b0);
        end
        sb.push_back(mk(tbl[9]));

        // Overlapping clusters in one frame
        drive(1'b1, 3'd0, 1'b1, 11'd100, 3'd3, 1'b0);
        drive(1'b0, 3'd1, 1'b1, 11'd102, 3'd1, 1'b0);
        for (int p = 2; p < 8; p++) drive(1'b0, 3'(p), 1'b0, NONE, 3'd0, 1'b0);
        f.map = range_map(100, 103); f.n = 4'd2; f.flags = 4'b0100;
        sb.push_back(f);

        // Eight clusters, then a ninth word one pass past the wrap
        drive(1'b1, 3'd0, 1'b1, 11'd0, 3'd7, 1'b0);
        f.map = range_map(0, 7);
        for (int k = 1; k < 8; k++) begin
            drive(1'b0, 3'(k), 1'b1, 11'(20 * k), 3'd7, 1'b0);
            f.map = f.map | range_map(20 * k, 20 * k + 7);
        end
        drive(1'b0, 3'd0, 1'b1, 11'd200, 3'd0, 1'b0);
        f.n = 4'd8; f.flags = 4'b1000;
        sb.push_back(f);

        // Short frame: sync after only two passes
        drive(1'b1, 3'd0, 1'b0, NONE, 3'd0, 1'b0);
        drive(1'b0, 3'd1, 1'b0, NONE, 3'd0, 1'b0);
        f.map = '0; f.n = 4'd0; f.flags = 4'b0000;
        sb.push_back(f);
        drive(1'b1, 3'd0, 1'b0, NONE, 3'd0, 1'b1);

        // Pass sequence 0,1,3 then the counter carries on 3..7
        drive(1'b0, 3'd1, 1'b1, 11'd600, 3'd2, 1'b0);
        drive(1'b0, 3'd3, 1'b0, NONE, 3'd0, 1'b1);
        for (int p = 3; p < 8; p++) drive(1'b0, 3'(p), 1'b0, NONE, 3'd0, 1'b0);
        f.map = range_map(600, 602); f.n = 4'd1; f.flags = 4'b0000;
        sb.push_back(f);
        drive(1'b1, 3'd0, 1'b0, NONE, 3'd0, 1'b0);

        // Reset mid-frame after three clusters: partial frame discarded
        drive(1'b0, 3'd1, 1'b1, 11'd300, 3'd1, 1'b0);
        drive(1'b0, 3'd2, 1'b1, 11'd310, 3'd1, 1'b0);
        drive(1'b0, 3'd3, 1'b1, 11'd320, 3'd1, 1'b0);
        reset = 1'b1;
        repeat (2) drive(1'b0, 3'd4, 1'b0, NONE, 3'd0, 1'b0);
        reset = 1'b0;
        chk("mid reset vpfs_out zero", 32'(vpfs_out !== '0), 32'd0);
        chk("mid reset n_clusters", 32'(n_clusters), 32'd0);
        chk("mid reset err_flags", 32'(err_flags), 32'd0);
        drive(1'b0, 3'd5, 1'b1, 11'd400, 3'd0, 1'b0);
        drive(1'b1, 3'd0, 1'b1, 11'd500, 3'd0, 1'b0);
        for (int p = 1; p < 8; p++) drive(1'b0, 3'(p), 1'b0, NONE, 3'd0, 1'b0);
        f.map = range_map(500, 500); f.n = 4'd1; f.flags = 4'b0000;
        sb.push_back(f);
        drive(1'b1, 3'd0, 1'b0, NONE, 3'd0, 1'b0);
        for (int p = 1; p < 8; p++) drive(1'b0, 3'(p), 1'b0, NONE, 3'd0, 1'b0);

        for (int w = 0; w < 20 && sb.size() != 0; w++) @(negedge clock);
        chk("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
